// File: rtl/segment_descriptor_loader.sv
// Purpose: selects GDT/LDT from a selector, bound-checks, fetches the 8-byte descriptor, validates it.
// Latency: 2 cycles (null/table fault); 5 (32-bit bus) or 4 (64-bit bus) zero-wait; +1 per bus wait cycle.
// Backpressure: bus_valid/bus_address held until bus_ready; valid is only sampled while IDLE.
// Optional: define SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN to write the accessed bit back after a clean load.
// Ports: clock/reset_n; request (valid, selector, cpl, target_stack) and table registers (gdt_*, ldt_*);
//        read bus (bus_valid, bus_address, bus_read_data, bus_ready, bus_write, bus_write_data);
//        result (ready pulse, segment_base/limit/access/flags, is_null, fault, fault_error_code).
module segment_descriptor_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BUS_DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      valid,
    output logic                      ready,
    input  logic [15:0]               selector,
    input  logic [1:0]                cpl,
    input  logic                      target_stack,
    input  logic [ADDR_WIDTH-1:0]     gdt_base,
    input  logic [15:0]               gdt_limit,
    input  logic [ADDR_WIDTH-1:0]     ldt_base,
    input  logic [31:0]               ldt_limit,
    input  logic                      ldt_present,
    output logic                      bus_valid,
    output logic [ADDR_WIDTH-1:0]     bus_address,
    input  logic [BUS_DATA_WIDTH-1:0] bus_read_data,
    input  logic                      bus_ready,
    output logic                      bus_write,
    output logic [31:0]               bus_write_data,
    output logic [31:0]               segment_base,
    output logic [31:0]               segment_limit,
    output logic [7:0]                segment_access,
    output logic [3:0]                segment_flags,
    output logic                      is_null,
    output logic [1:0]                fault,
    output logic [15:0]               fault_error_code
);
    // Bound compare is done one bit wider than both the address and the 32-bit LDT limit so it never wraps.
    localparam int CW = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;
    localparam logic [1:0] F_NONE = 2'd0, F_GP = 2'd1, F_NP = 2'd2, F_SS = 2'd3;

`ifdef SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ_LO, S_READ_HI, S_VALIDATE, S_WRITEBACK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ_LO, S_READ_HI, S_VALIDATE, S_DONE} state_t;
`endif

    state_t                state, state_nxt;
    logic [15:0]           sel_q;
    logic [1:0]            cpl_q;
    logic                  stack_q;
    logic [63:0]           desc_q, desc_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  res_ld, res_null, res_ok;
    logic [1:0]            res_fault, val_fault;

    logic [12:0]           index;
    logic                  ti, null_sel, out_of_bounds, is_code;
    logic [1:0]            rpl, dpl, eff_priv;
    logic [CW-1:0]         desc_end, table_limit;
    logic [ADDR_WIDTH-1:0] desc_addr;
    logic [7:0]            acc, dec_access;
    logic [31:0]           dec_base, dec_limit;

    assign index         = sel_q[15:3];
    assign ti            = sel_q[2];
    assign rpl           = sel_q[1:0];
    assign null_sel      = (index == 13'd0) && !ti;
    assign desc_end      = CW'({index, 3'b111});
    assign table_limit   = ti ? CW'(ldt_limit) : CW'(gdt_limit);
    assign out_of_bounds = desc_end > table_limit;
    assign desc_addr     = (ti ? ldt_base : gdt_base) + ADDR_WIDTH'({index, 3'b000});

    assign acc       = desc_q[47:40];
    assign dpl       = acc[6:5];
    assign is_code   = acc[3];
    assign eff_priv  = (cpl_q > rpl) ? cpl_q : rpl;
    assign dec_base  = {desc_q[63:56], desc_q[39:16]};
    assign dec_limit = desc_q[55] ? {desc_q[51:48], desc_q[15:0], 12'hFFF}
                                  : {12'h000, desc_q[51:48], desc_q[15:0]};
    assign res_ok    = (res_fault == F_NONE) && !res_null;

    assign ready     = (state == S_DONE);

`ifdef SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN
    logic [ADDR_WIDTH-1:0] desc_addr_q;
    // A clean load always leaves the accessed bit set in memory, so report it set.
    assign dec_access     = acc | 8'h01;
    assign bus_valid      = (state == S_READ_LO) || (state == S_READ_HI) || (state == S_WRITEBACK);
    assign bus_write      = (state == S_WRITEBACK);
    assign bus_write_data = bus_write ? (desc_q[63:32] | 32'h0000_0100) : 32'h0;
`else
    assign dec_access     = acc;
    assign bus_valid      = (state == S_READ_LO) || (state == S_READ_HI);
    assign bus_write      = 1'b0;
    assign bus_write_data = 32'h0;
`endif

    // Access-rights checks, highest priority first.
    always_comb begin
        val_fault = F_NONE;
        if (!acc[4]) begin
            val_fault = F_GP;
        end else if (!stack_q) begin
            if (is_code && !acc[1])                         val_fault = F_GP;
            else if ((!is_code || !acc[2]) && eff_priv > dpl) val_fault = F_GP;
            else if (!acc[7])                                 val_fault = F_NP;
        end else begin
            if (rpl != cpl_q || dpl != cpl_q || is_code || !acc[1]) val_fault = F_GP;
            else if (!acc[7])                                        val_fault = F_SS;
        end
    end

    always_comb begin
        state_nxt = state;
        desc_nxt  = desc_q;
        addr_nxt  = bus_address;
        res_ld    = 1'b0;
        res_fault = F_NONE;
        res_null  = 1'b0;
        case (state)
            S_IDLE: if (valid) state_nxt = S_CHECK;
            S_CHECK: begin
                if (null_sel) begin
                    res_ld    = 1'b1;
                    res_fault = stack_q ? F_GP : F_NONE;
                    res_null  = !stack_q;
                    state_nxt = S_DONE;
                end else if ((ti && !ldt_present) || out_of_bounds) begin
                    res_ld    = 1'b1;
                    res_fault = F_GP;
                    state_nxt = S_DONE;
                end else begin
                    addr_nxt  = desc_addr;
                    state_nxt = S_READ_LO;
                end
            end
            S_READ_LO: if (bus_ready) begin
                if (BUS_DATA_WIDTH == 64) begin
                    desc_nxt  = 64'(bus_read_data);
                    state_nxt = S_VALIDATE;
                end else begin
                    desc_nxt[31:0] = bus_read_data[31:0];
                    addr_nxt       = bus_address + ADDR_WIDTH'(4);
                    state_nxt      = S_READ_HI;
                end
            end
            S_READ_HI: if (bus_ready) begin
                desc_nxt[63:32] = bus_read_data[31:0];
                state_nxt       = S_VALIDATE;
            end
            S_VALIDATE: begin
                res_ld    = 1'b1;
                res_fault = val_fault;
                state_nxt = S_DONE;
`ifdef SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN
                if (val_fault == F_NONE && !desc_q[40]) begin
                    addr_nxt  = desc_addr_q + ADDR_WIDTH'(4);
                    state_nxt = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                if (bus_ready) state_nxt = S_DONE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            sel_q            <= 16'h0;
            cpl_q            <= 2'd0;
            stack_q          <= 1'b0;
            desc_q           <= 64'h0;
            bus_address      <= '0;
            segment_base     <= 32'h0;
            segment_limit    <= 32'h0;
            segment_access   <= 8'h0;
            segment_flags    <= 4'h0;
            is_null          <= 1'b0;
            fault            <= F_NONE;
            fault_error_code <= 16'h0;
`ifdef SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN
            desc_addr_q      <= '0;
`endif
        end else begin
            state       <= state_nxt;
            desc_q      <= desc_nxt;
            bus_address <= addr_nxt;
            if (state == S_IDLE && valid) begin
                sel_q   <= selector;
                cpl_q   <= cpl;
                stack_q <= target_stack;
            end
`ifdef SEGMENT_DESCRIPTOR_ACCESSED_WRITEBACK_EN
            if (state == S_CHECK) desc_addr_q <= desc_addr;
`endif
            if (res_ld) begin
                fault            <= res_fault;
                fault_error_code <= (res_fault != F_NONE) ? (sel_q & 16'hFFFC) : 16'h0;
                is_null          <= res_null;
                segment_base     <= res_ok ? dec_base : 32'h0;
                segment_limit    <= res_ok ? dec_limit : 32'h0;
                segment_access   <= res_ok ? dec_access : 8'h0;
                segment_flags    <= res_ok ? desc_q[55:52] : 4'h0;
            end
        end
    end
endmodule

// File: tb/tb_segment_descriptor_loader.sv
module tb_segment_descriptor_loader;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic [15:0] selector = '0;
    logic [1:0]  cpl = '0;
    logic        target_stack = 1'b0;
    logic [31:0] gdt_base = '0;
    logic [15:0] gdt_limit = '0;
    logic [31:0] ldt_base = '0;
    logic [31:0] ldt_limit = '0;
    logic        ldt_present = 1'b0;

    logic        valid32 = 1'b0, valid64 = 1'b0, brdy32 = 1'b0, brdy64 = 1'b0;
    logic [31:0] rdata32 = '0;
    logic [63:0] rdata64 = '0;
    logic        ready32, ready64, bvld32, bvld64, bwr32, bwr64, null32, null64;
    logic [31:0] badr32, badr64, bwd32, bwd64, base32, base64, lim32, lim64;
    logic [7:0]  acc32, acc64;
    logic [3:0]  flg32, flg64;
    logic [1:0]  flt32, flt64;
    logic [15:0] err32, err64;

    segment_descriptor_loader #(.ADDR_WIDTH(32), .BUS_DATA_WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .valid(valid32), .ready(ready32),
        .selector(selector), .cpl(cpl), .target_stack(target_stack),
        .gdt_base(gdt_base), .gdt_limit(gdt_limit), .ldt_base(ldt_base), .ldt_limit(ldt_limit),
        .ldt_present(ldt_present), .bus_valid(bvld32), .bus_address(badr32),
        .bus_read_data(rdata32), .bus_ready(brdy32), .bus_write(bwr32), .bus_write_data(bwd32),
        .segment_base(base32), .segment_limit(lim32), .segment_access(acc32), .segment_flags(flg32),
        .is_null(null32), .fault(flt32), .fault_error_code(err32));

    segment_descriptor_loader #(.ADDR_WIDTH(32), .BUS_DATA_WIDTH(64)) dut64 (
        .clock(clock), .reset_n(reset_n), .valid(valid64), .ready(ready64),
        .selector(selector), .cpl(cpl), .target_stack(target_stack),
        .gdt_base(gdt_base), .gdt_limit(gdt_limit), .ldt_base(ldt_base), .ldt_limit(ldt_limit),
        .ldt_present(ldt_present), .bus_valid(bvld64), .bus_address(badr64),
        .bus_read_data(rdata64), .bus_ready(brdy64), .bus_write(bwr64), .bus_write_data(bwd64),
        .segment_base(base64), .segment_limit(lim64), .segment_access(acc64), .segment_flags(flg64),
        .is_null(null64), .fault(flt64), .fault_error_code(err64));

    logic        use64 = 1'b0;
    wire         m_ready = use64 ? ready64 : ready32;
    wire  [1:0]  m_fault = use64 ? flt64 : flt32;
    wire  [15:0] m_err   = use64 ? err64 : err32;
    wire         m_null  = use64 ? null64 : null32;
    wire  [31:0] m_base  = use64 ? base64 : base32;
    wire  [31:0] m_limit = use64 ? lim64 : lim32;
    wire  [7:0]  m_acc   = use64 ? acc64 : acc32;
    wire  [3:0]  m_flags = use64 ? flg64 : flg32;

    // Memory model: 32-bit words keyed by byte address; unwritten words read as 0.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_log [$];
    int wait_cycles = 0, wc32 = 0, wc64 = 0, vcyc = 0, wr_seen = 0, rp32 = 0, rp64 = 0;
    int total = 0, bad = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Bus responder: each beat waits wait_cycles cycles, then is accepted.
    always @(negedge clock) begin
        if (ready32) rp32++;
        if (ready64) rp64++;
        if (bwr32 || bwr64) wr_seen++;
        if (bvld32) begin
            vcyc++;
            if (wc32 >= wait_cycles) begin
                brdy32 = 1'b1; rdata32 = rd(badr32); addr_log.push_back(badr32); wc32 = 0;
            end else begin
                brdy32 = 1'b0; wc32++;
            end
        end else begin
            brdy32 = 1'b0; wc32 = 0;
        end
        if (bvld64) begin
            vcyc++;
            if (wc64 >= wait_cycles) begin
                brdy64 = 1'b1; rdata64 = {rd(badr64 + 32'd4), rd(badr64)}; addr_log.push_back(badr64); wc64 = 0;
            end else begin
                brdy64 = 1'b0; wc64++;
            end
        end else begin
            brdy64 = 1'b0; wc64 = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int lat; int beats; logic [31:0] addr;
        logic [1:0] fault; logic [15:0] err; logic nul;
        logic [31:0] base; logic [31:0] limit; logic [7:0] acc; logic [3:0] flags;
    } exp_t;

    // Reference: expected outcome of one load from the architectural rules.
    function automatic exp_t model(input logic [15:0] sel, input logic [1:0] c, input logic stk,
                                   input logic [63:0] d, input logic b64, input int w);
        exp_t e;
        int idx = int'(sel[15:3]);
        int rpl = int'(sel[1:0]);
        int cp  = int'(c);
        int dpl = int'(d[46:45]);
        int priv = (cp > rpl) ? cp : rpl;
        longint tbl_lim = sel[2] ? longint'(ldt_limit) : longint'(gdt_limit);
        logic p = d[47], s = d[44], code = d[43], conf = d[42], rw = d[41];
        e.lat = 2; e.beats = 0; e.fault = 0; e.err = 0; e.nul = 0;
        e.base = 0; e.limit = 0; e.acc = 0; e.flags = 0;
        e.addr = (sel[2] ? ldt_base : gdt_base) + 32'(idx) * 32'd8;
        if (idx == 0 && !sel[2]) begin
            if (stk) e.fault = 1; else e.nul = 1;
        end else if (sel[2] && !ldt_present) begin
            e.fault = 1;
        end else if (longint'(idx) * 8 + 7 > tbl_lim) begin
            e.fault = 1;
        end else begin
            e.beats = b64 ? 1 : 2;
            e.lat = 3 + e.beats * (1 + w);
            if (!s) e.fault = 1;
            else if (!stk) begin
                if (code && !rw) e.fault = 1;
                else if ((!code || !conf) && priv > dpl) e.fault = 1;
                else if (!p) e.fault = 2;
            end else begin
                if (rpl != cp || dpl != cp || code || !rw) e.fault = 1;
                else if (!p) e.fault = 3;
            end
            if (e.fault == 0) begin
                e.base  = {d[63:56], d[39:16]};
                e.limit = d[55] ? 32'({d[51:48], d[15:0]}) * 32'd4096 + 32'hFFF : 32'({d[51:48], d[15:0]});
                e.acc   = d[47:40];
                e.flags = d[55:52];
            end
        end
        if (e.fault != 0) e.err = sel & 16'hFFFC;
        return e;
    endfunction

    task automatic run(input string tag, input logic [15:0] sel, input logic [1:0] c, input logic stk,
                       input logic [63:0] d, input logic b64, input int w);
        exp_t e;
        int n, l0, v0;
        e = model(sel, c, stk, d, b64, w);
        mem[e.addr] = d[31:0];
        mem[e.addr + 32'd4] = d[63:32];
        use64 = b64; wait_cycles = w; selector = sel; cpl = c; target_stack = stk;
        l0 = addr_log.size(); v0 = vcyc;
        if (b64) valid64 = 1'b1; else valid32 = 1'b1;
        @(posedge clock); #1;
        valid32 = 1'b0; valid64 = 1'b0;
        n = 1;
        while (!m_ready && n < 60) begin
            @(posedge clock); #1; n++;
        end
        chk({tag, ".latency"}, n, e.lat);
        chk({tag, ".fault"}, m_fault, e.fault);
        chk({tag, ".errcode"}, m_err, e.err);
        chk({tag, ".is_null"}, m_null, e.nul);
        chk({tag, ".base"}, m_base, e.base);
        chk({tag, ".limit"}, m_limit, e.limit);
        chk({tag, ".access"}, m_acc, e.acc);
        if (e.fault == 0 && !e.nul) chk({tag, ".flags"}, m_flags, e.flags);
        chk({tag, ".beats"}, addr_log.size() - l0, e.beats);
        chk({tag, ".valid_cycles"}, vcyc - v0, e.beats * (1 + w));
        if (e.beats > 0 && addr_log.size() > l0) chk({tag, ".addr0"}, addr_log[l0], e.addr);
        if (e.beats > 1 && addr_log.size() > l0 + 1) chk({tag, ".addr1"}, addr_log[l0 + 1], e.addr + 32'd4);
        @(posedge clock); #1;
        chk({tag, ".ready_pulse"}, m_ready, 1'b0);
    endtask

    logic [63:0] rdesc;
    logic [15:0] rsel;
    logic [1:0]  rcpl;
    int          n, l0, rp0;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst.ready32", ready32, 1'b0);
        chk("rst.bus_valid32", bvld32, 1'b0);
        chk("rst.bus_address32", badr32, 32'h0);
        chk("rst.bus_write32", bwr32, 1'b0);
        chk("rst.fault32", flt32, 2'd0);
        chk("rst.base64", base64, 32'h0);
        chk("rst.ready64", ready64, 1'b0);
        chk("rst.bus_valid64", bvld64, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        gdt_base = 32'h0000_1000; gdt_limit = 16'h00FF;
        ldt_base = 32'h0000_2000; ldt_limit = 32'h0000_00FF; ldt_present = 1'b0;
        run("gdt_load", 16'h0010, 2'd0, 1'b0, 64'h00CF_9200_0000_FFFF, 1'b0, 0);
        chk("gdt_load.limit_const", lim32, 32'hFFFF_FFFF);
        chk("gdt_load.access_const", acc32, 8'h92);
        run("oob", 16'h0100, 2'd0, 1'b0, 64'h00CF_9200_0000_FFFF, 1'b0, 0);
        run("null_data", 16'h0003, 2'd0, 1'b0, 64'h0, 1'b0, 0);
        run("null_stack", 16'h0003, 2'd0, 1'b1, 64'h0, 1'b0, 0);
        run("ldt_absent", 16'h000C, 2'd0, 1'b0, 64'h0000_1200_0000_FFFF, 1'b0, 0);
        ldt_present = 1'b1;
        run("ldt_np_data", 16'h000C, 2'd0, 1'b0, 64'h0000_1200_0000_FFFF, 1'b0, 0);
        run("ldt_np_stack", 16'h000C, 2'd0, 1'b1, 64'h0000_1200_0000_FFFF, 1'b0, 1);
        run("priv_gp", 16'h001B, 2'd3, 1'b0, 64'h0000_9200_0000_FFFF, 1'b0, 0);
        run("priv_ok64", 16'h001B, 2'd3, 1'b0, 64'h1240_F234_5678_00FF, 1'b1, 3);
        chk("priv_ok64.base_const", base64, 32'h1234_5678);

        // Reset pulse while the second beat of a 32-bit fetch is outstanding.
        use64 = 1'b0; wait_cycles = 2; selector = 16'h0010; cpl = 2'd0; target_stack = 1'b0;
        l0 = addr_log.size(); rp0 = rp32;
        valid32 = 1'b1;
        @(posedge clock); #1;
        valid32 = 1'b0;
        n = 0;
        while (addr_log.size() == l0 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        chk("rst_mid.in_read_hi", bvld32, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid.valid_drop", bvld32, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mid.no_ready", rp32 - rp0, 0);
        chk("rst_mid.bus_address", badr32, 32'h0);
        chk("rst_mid.fault", flt32, 2'd0);
        chk("rst_mid.base", base32, 32'h0);
        chk("rst_mid.limit", lim32, 32'h0);
        chk("rst_mid.access", acc32, 8'h0);
        chk("rst_mid.errcode", err32, 16'h0);
        chk("rst_mid.is_null", null32, 1'b0);
        gdt_base = 32'h0000_1000; gdt_limit = 16'h00FF;
        run("post_reset", 16'h0010, 2'd0, 1'b0, 64'h00CF_9200_0000_FFFF, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            gdt_base    = $urandom;
            gdt_limit   = 16'($urandom_range(0, 1023));
            ldt_base    = $urandom;
            ldt_limit   = $urandom_range(0, 1023);
            ldt_present = ($urandom_range(0, 3) != 0);
            rsel  = {13'($urandom_range(0, 130)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            rcpl  = 2'($urandom_range(0, 3));
            rdesc = {$urandom, $urandom};
            rdesc[47] = ($urandom_range(0, 7) != 0);
            rdesc[44] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                rcpl = rsel[1:0];
                rdesc[46:45] = rsel[1:0];
            end
            run($sformatf("rand%0d", k), rsel, rcpl, 1'($urandom_range(0, 1)), rdesc,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        chk("no_bus_writes", wr_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
